gr_wb_ctrl: RTL
===============

GR_WB_CTRL -- requirements
Module: gr_wb_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first (name dir width meaning):
 m_clock in 1 sole clock, rising edge; p_reset in 1 reset, active-low, asynchronous.
 alu_valid in 1, alu_ready out 1, alu_rd_n in 5, alu_wd in 32: ALU result channel.
 ld_valid in 1, ld_ready out 1, ld_rd_n in 5, ld_wd in 32: load result channel.
 res in 1, res_n in 5: issue-stage reservation of a destination register.
 rs1_n in 5, rs2_n in 5: source register queries.
 rs1_busy out 1, rs2_busy out 1: a pending write exists for the queried register.
 rd out 1, rd_n out 5, wd out 32: register-file write port (write enable, index, data).
 fwd1_hit out 1, fwd1_d out 32, fwd2_hit out 1, fwd2_d out 32: bypass outputs.
REQ-002 SHALL have no parameters; index width 5, data width 32, 32 registers.

Function
REQ-003 Each channel SHALL own a one-entry holding buffer; transfer when valid&ready on a rising edge.
REQ-004 x_ready SHALL be 1 when that buffer is empty, or full and draining this cycle.
REQ-005 At most one buffer entry SHALL drain per cycle into the output register (rd, rd_n, wd).
REQ-006 Arbitration: load wins when both buffers are full, except that an ALU entry that lost once SHALL win the next cycle (1-bit age flag; no starvation).
REQ-007 Latency: accept at edge N; earliest drain at edge N+1; rd=1 during cycle N+1..N+2; register file writes at edge N+2.
REQ-008 rd SHALL be high for exactly one cycle per drained entry with nonzero index; entries with index 0 drain but leave rd=0.
REQ-009 Scoreboard: 32-bit busy vector; res=1 with res_n!=0 sets busy[res_n] at the edge.
REQ-010 rd=1 SHALL clear busy[rd_n] at the edge that completes the write.
REQ-011 Set and clear of the same index on the same edge: set wins.
REQ-012 rsK_busy = busy[rsK_n], combinational; always 0 for index 0.
REQ-013 Back-to-back drains SHALL sustain one write per cycle with no bubble.

Reset
REQ-014 p_reset low SHALL immediately clear both buffers, busy vector, age flag, rd, rd_n, wd, fwd outputs to 0.
REQ-015 Entries in flight at reset SHALL be discarded, with no write issued; alu_ready and ld_ready read 1 on the first cycle after release.

Configuration
REQ-016 With GR_WB_FWD_EN defined: fwdK_hit = rd & (rd_n==rsK_n) & (rsK_n!=0); fwdK_d = wd when hit, else 0; rsK_busy SHALL be forced 0 on a hit.
REQ-017 Without GR_WB_FWD_EN: fwdK_hit and fwdK_d are tied to 0; rsK_busy follows REQ-012 only.

Structure
REQ-018 Shared package gr_pkg SHALL hold: register-index width (5), data width (32), register count (32), and a result-entry type {valid, idx[4:0], data[31:0]}.
REQ-019 Sub-module gr_wb_slot (one-entry holding buffer with ready logic) SHALL be instantiated once per channel.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
 ALU only: alu x5=0x1234 at edge 1 -> rd=1, rd_n=5, wd=0x1234 during cycle 2-3; busy[5] clears at edge 3.
 Collision: ALU x3=0xA and load x4=0xB both accepted at edge 1 -> x4 written first (edge 3), x3 next (edge 4); no loss.
 x0: load x0=0xFFFF_FFFF -> ld_ready returns 1, rd stays 0, rs1_busy(rs1_n=0)=0.
 Scoreboard: res x7 at edge 1, ALU x7 at edge 2 -> rs1_busy(7)=1 from cycle 1 until the write edge; reserve x7 again on that edge -> busy stays 1.
 Forward (GR_WB_FWD_EN): rd=1, rd_n=9, wd=0x55, rs2_n=9 -> fwd2_hit=1, fwd2_d=0x55, rs2_busy=0; without the macro, fwd2_hit=0.
 Reset: assert p_reset low with both buffers full -> all outputs 0 within the cycle, no rd pulse after release, both ready=1.

Source files
------------

// File: rtl/gr_pkg.sv
// ---------------------------------------------------------------------------
// gr_pkg -- shared definitions for the writeback controller slice.
//   GR_IDX_W   : register index width
//   GR_DATA_W  : register data width
//   GR_NREGS   : number of architectural registers
//   gr_entry_t : one pending result {valid, idx, data}
// ---------------------------------------------------------------------------
package gr_pkg;

    localparam int GR_IDX_W  = 5;
    localparam int GR_DATA_W = 32;
    localparam int GR_NREGS  = 32;

    typedef struct packed {
        logic                 valid;
        logic [GR_IDX_W-1:0]  idx;
        logic [GR_DATA_W-1:0] data;
    } gr_entry_t;

endpackage

// File: rtl/gr_wb_slot.sv
// ---------------------------------------------------------------------------
// gr_wb_slot -- one-entry holding buffer for a result channel.
//   m_clock   in  : clock, rising edge
//   p_reset   in  : asynchronous active-low reset (discards the entry)
//   in_valid  in  : producer offers a result
//   in_idx    in  : destination register index
//   in_data   in  : result data
//   drain     in  : arbiter takes the held entry this cycle
//   in_ready  out : slot can accept this cycle (empty, or emptying now)
//   entry     out : held entry
// ---------------------------------------------------------------------------
module gr_wb_slot
    import gr_pkg::*;
(
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic                 in_valid,
    input  logic [GR_IDX_W-1:0]  in_idx,
    input  logic [GR_DATA_W-1:0] in_data,
    input  logic                 drain,
    output logic                 in_ready,
    output gr_entry_t            entry
);

    // Accepting while draining lets one result per cycle stream through.
    assign in_ready = !entry.valid || drain;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            entry <= '0;
        end else if (in_valid && in_ready) begin
            entry.valid <= 1'b1;
            entry.idx   <= in_idx;
            entry.data  <= in_data;
        end else if (drain) begin
            entry <= '0;
        end
    end

endmodule

// File: rtl/gr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// gr_wb_ctrl -- writeback controller: merges ALU and load results into a
// single register-file write port and tracks pending writes.
//
// Optional feature: define GR_WB_FWD_EN to enable bypass from the write
// port to the source-register queries.
//
// Ports:
//   m_clock, p_reset (active-low, async)
//   alu_valid/alu_ready/alu_rd_n/alu_wd : ALU result channel
//   ld_valid/ld_ready/ld_rd_n/ld_wd     : load result channel
//   res, res_n                          : reserve a destination register
//   rs1_n, rs2_n / rs1_busy, rs2_busy   : pending-write queries
//   rd, rd_n, wd                        : register-file write port
//   fwd1_hit/fwd1_d, fwd2_hit/fwd2_d    : bypass outputs
// ---------------------------------------------------------------------------
module gr_wb_ctrl
    import gr_pkg::*;
(
    input  logic                 m_clock,
    input  logic                 p_reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [GR_IDX_W-1:0]  alu_rd_n,
    input  logic [GR_DATA_W-1:0] alu_wd,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [GR_IDX_W-1:0]  ld_rd_n,
    input  logic [GR_DATA_W-1:0] ld_wd,
    input  logic                 res,
    input  logic [GR_IDX_W-1:0]  res_n,
    input  logic [GR_IDX_W-1:0]  rs1_n,
    input  logic [GR_IDX_W-1:0]  rs2_n,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rd,
    output logic [GR_IDX_W-1:0]  rd_n,
    output logic [GR_DATA_W-1:0] wd,
    output logic                 fwd1_hit,
    output logic [GR_DATA_W-1:0] fwd1_d,
    output logic                 fwd2_hit,
    output logic [GR_DATA_W-1:0] fwd2_d
);

    gr_entry_t              alu_e;
    gr_entry_t              ld_e;
    logic                   grant_alu;
    logic                   grant_ld;
    logic                   age;
    logic [GR_IDX_W-1:0]    drain_idx;
    logic [GR_DATA_W-1:0]   drain_data;
    logic [GR_NREGS-1:0]    busy;
    logic [GR_NREGS-1:0]    busy_next;
    logic                   rs1_sb;
    logic                   rs2_sb;

    gr_wb_slot u_alu_slot (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .in_valid (alu_valid),
        .in_idx   (alu_rd_n),
        .in_data  (alu_wd),
        .drain    (grant_alu),
        .in_ready (alu_ready),
        .entry    (alu_e)
    );

    gr_wb_slot u_ld_slot (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .in_valid (ld_valid),
        .in_idx   (ld_rd_n),
        .in_data  (ld_wd),
        .drain    (grant_ld),
        .in_ready (ld_ready),
        .entry    (ld_e)
    );

    // Load normally wins; age remembers that the ALU entry already lost
    // once, so it takes the next slot and cannot starve.
    always_comb begin
        grant_alu  = alu_e.valid && (!ld_e.valid || age);
        grant_ld   = ld_e.valid && !grant_alu;
        drain_idx  = grant_alu ? alu_e.idx  : ld_e.idx;
        drain_data = grant_alu ? alu_e.data : ld_e.data;
    end

    // Set is applied after clear so a same-edge reservation survives.
    always_comb begin
        busy_next = busy;
        if (rd) begin
            busy_next[rd_n] = 1'b0;
        end
        if (res && (res_n != '0)) begin
            busy_next[res_n] = 1'b1;
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            age  <= 1'b0;
            rd   <= 1'b0;
            rd_n <= '0;
            wd   <= '0;
            busy <= '0;
        end else begin
            age  <= alu_e.valid && ld_e.valid && grant_ld;
            busy <= busy_next;
            if (grant_alu || grant_ld) begin
                // Index-0 entries drain silently: x0 is never written.
                rd   <= (drain_idx != '0);
                rd_n <= drain_idx;
                wd   <= drain_data;
            end else begin
                rd   <= 1'b0;
            end
        end
    end

    assign rs1_sb = busy[rs1_n] && (rs1_n != '0);
    assign rs2_sb = busy[rs2_n] && (rs2_n != '0);

`ifdef GR_WB_FWD_EN
    // A write in progress satisfies the query, so it no longer reads busy.
    assign fwd1_hit = rd && (rd_n == rs1_n) && (rs1_n != '0);
    assign fwd2_hit = rd && (rd_n == rs2_n) && (rs2_n != '0);
    assign fwd1_d   = fwd1_hit ? wd : '0;
    assign fwd2_d   = fwd2_hit ? wd : '0;
    assign rs1_busy = rs1_sb && !fwd1_hit;
    assign rs2_busy = rs2_sb && !fwd2_hit;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
    assign fwd1_d   = '0;
    assign fwd2_d   = '0;
    assign rs1_busy = rs1_sb;
    assign rs2_busy = rs2_sb;
`endif

endmodule
